// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Optional stall-cycle counter is enabled by defining PIPE_STALL_CNT_EN.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
  localparam logic [4:0] REG_ZERO      = 5'd0;

  // Bit positions of the per-stage enables inside the internal WE_n vector
  localparam int STG_F   = 0;
  localparam int STG_D   = 1;
  localparam int STG_E   = 2;
  localparam int STG_M   = 3;
  localparam int STG_W   = 4;
  localparam int NUM_STG = 5;

  localparam logic [NUM_STG-1:0] WE_LOAD_ALL = '0;
  localparam logic [NUM_STG-1:0] WE_HOLD_ALL = '1;
  // Load-use: hold PC and IF/ID, let E/M/W drain while ID/EX takes a bubble
  localparam logic [NUM_STG-1:0] WE_LOAD_USE = 5'b00011;

  function automatic logic load_use_hazard(
    input logic [1:0] memtoreg_e,
    input logic [4:0] writereg_e,
    input logic [4:0] rs_d,
    input logic [4:0] rt_d
  );
    return (memtoreg_e == MEMTOREG_LOAD) &&
           (writereg_e != REG_ZERO) &&
           ((writereg_e == rs_d) || (writereg_e == rt_d));
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Bundle of memory handshake, hazard inputs and stage-enable outputs of the
// stall sequencer; master = the sequencer, slave = pipeline/memory side.
interface pipe_stall_ctrl_if;

  logic        i_MemRead_M;
  logic        i_MemWrite_M;
  logic        i_MemAck;
  logic [1:0]  i_MemtoReg_E;
  logic [4:0]  i_WriteReg_E;
  logic [4:0]  i_Rs_D;
  logic [4:0]  i_Rt_D;

  logic        o_MemReq;
  logic        o_WE_n_F;
  logic        o_WE_n_D;
  logic        o_WE_n_E;
  logic        o_WE_n_M;
  logic        o_WE_n_W;
  logic        o_Flush_E;
  logic        o_BusErr;
  logic [31:0] o_StallCnt;

  modport master (
    input  i_MemRead_M, i_MemWrite_M, i_MemAck, i_MemtoReg_E,
           i_WriteReg_E, i_Rs_D, i_Rt_D,
    output o_MemReq, o_WE_n_F, o_WE_n_D, o_WE_n_E, o_WE_n_M, o_WE_n_W,
           o_Flush_E, o_BusErr, o_StallCnt
  );

  modport slave (
    output i_MemRead_M, i_MemWrite_M, i_MemAck, i_MemtoReg_E,
           i_WriteReg_E, i_Rs_D, i_Rt_D,
    input  o_MemReq, o_WE_n_F, o_WE_n_D, o_WE_n_E, o_WE_n_M, o_WE_n_W,
           o_Flush_E, o_BusErr, o_StallCnt
  );

endinterface

// File: rtl/pipe_stall_ctrl_wait_timer.sv
// Memory-wait cycle counter; tc flags the last permitted wait cycle
// (count == TIMEOUT_CYCLES-1).
module pipe_wait_timer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic i_Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge i_Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tc = (cnt_reg == TC_VAL);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze,
// load-use bubbles and memory timeout trap. PIPE_STALL_CNT_EN adds a stall counter.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic                i_Clk,
  input  logic                Reset,
  pipe_stall_ctrl_if.master   bus
);

  state_t               state_reg;
  state_t               state_next;
  logic                 bus_err_reg;
  logic [NUM_STG-1:0]   we_n_comb;
  logic [NUM_STG-1:0]   we_n_out;
  logic                 mem_req_comb;
  logic                 flush_comb;
  logic                 acc;
  logic                 hazard;
  logic                 tmr_clr;
  logic                 tmr_en;
  logic                 tmr_tc;

  assign acc    = bus.i_MemRead_M | bus.i_MemWrite_M;
  assign hazard = load_use_hazard(bus.i_MemtoReg_E, bus.i_WriteReg_E,
                                  bus.i_Rs_D, bus.i_Rt_D);

  pipe_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wait_timer (
    .i_Clk (i_Clk),
    .Reset (Reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  // Memory freeze takes priority over the load-use bubble: the hazard is
  // only looked at in RUN with no access pending.
  always_comb begin
    state_next   = state_reg;
    we_n_comb    = WE_HOLD_ALL;
    mem_req_comb = 1'b0;
    flush_comb   = 1'b0;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    case (state_reg)
      RUN: begin
        if (acc) begin
          mem_req_comb = 1'b1;
          if (bus.i_MemAck) begin
            we_n_comb = WE_LOAD_ALL;
          end else begin
            state_next = MEM_WAIT;
            tmr_clr    = 1'b1;
          end
        end else if (hazard) begin
          we_n_comb  = WE_LOAD_USE;
          flush_comb = 1'b1;
        end else begin
          we_n_comb = WE_LOAD_ALL;
        end
      end
      MEM_WAIT: begin
        mem_req_comb = 1'b1;
        if (bus.i_MemAck) begin
          we_n_comb  = WE_LOAD_ALL;
          state_next = RUN;
          tmr_clr    = 1'b1;
        end else if (tmr_tc) begin
          state_next = ERROR;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ERROR: begin
        state_next = ERROR;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= RUN;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next == ERROR) begin
        bus_err_reg <= 1'b1;
      end
    end
  end

  // Reset asserted overrides every enable to hold, immediately.
  for (genvar gi = 0; gi < NUM_STG; gi++) begin : g_we_n
    assign we_n_out[gi] = we_n_comb[gi] | ~Reset;
  end

  assign bus.o_WE_n_F  = we_n_out[STG_F];
  assign bus.o_WE_n_D  = we_n_out[STG_D];
  assign bus.o_WE_n_E  = we_n_out[STG_E];
  assign bus.o_WE_n_M  = we_n_out[STG_M];
  assign bus.o_WE_n_W  = we_n_out[STG_W];
  assign bus.o_MemReq  = mem_req_comb & Reset;
  assign bus.o_Flush_E = flush_comb & Reset;
  assign bus.o_BusErr  = bus_err_reg;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge i_Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt_reg <= '0;
    end else if (we_n_out[STG_F] && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign bus.o_StallCnt = stall_cnt_reg;
`else
  assign bus.o_StallCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: per-cycle stimulus tables with
// hand-derived expected enables, checked once per cycle.
module tb_pipe_stall_ctrl;

  logic i_Clk = 1'b0;
  logic Reset = 1'b0;

  pipe_stall_ctrl_if bus();

  pipe_stall_ctrl #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (16)
  ) dut (
    .i_Clk (i_Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 i_Clk = ~i_Clk;

  // outs packing: {WE_n_W, WE_n_M, WE_n_E, WE_n_D, WE_n_F, MemReq, Flush_E, BusErr}
  typedef struct {
    logic       rst;
    logic       rd;
    logic       wr;
    logic       ack;
    logic [1:0] m2r;
    logic [4:0] wreg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [7:0] outs;
  } cyc_t;

  typedef struct {
    logic [7:0]  outs;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks    = 0;
  int          failures  = 0;
  logic [31:0] stall_exp = '0;
  logic        last_f    = 1'b0;

  function automatic cyc_t mk(input logic rst, input logic rd, input logic wr,
                              input logic ack, input logic [1:0] m2r,
                              input logic [4:0] wreg, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [7:0] outs);
    cyc_t c;
    c.rst = rst; c.rd = rd; c.wr = wr; c.ack = ack; c.m2r = m2r;
    c.wreg = wreg; c.rs = rs; c.rt = rt; c.outs = outs;
    return c;
  endfunction

  function automatic logic [7:0] sample_outs();
    return {bus.o_WE_n_W, bus.o_WE_n_M, bus.o_WE_n_E, bus.o_WE_n_D,
            bus.o_WE_n_F, bus.o_MemReq, bus.o_Flush_E, bus.o_BusErr};
  endfunction

  // Drive one cycle of stimulus (from the falling edge) and queue its expectation.
  task automatic apply(input cyc_t c);
    exp_t e;
    Reset            = c.rst;
    bus.i_MemRead_M  = c.rd;
    bus.i_MemWrite_M = c.wr;
    bus.i_MemAck     = c.ack;
    bus.i_MemtoReg_E = c.m2r;
    bus.i_WriteReg_E = c.wreg;
    bus.i_Rs_D       = c.rs;
    bus.i_Rt_D       = c.rt;
    e.outs = c.outs;
`ifdef PIPE_STALL_CNT_EN
    e.cnt = stall_exp;
`else
    e.cnt = 32'd0;
`endif
    sb.push_back(e);
    last_f = c.outs[3];
    #2;
  endtask

  // Advance one clock; the stall-count model follows the expected PC enable.
  task automatic tick();
    @(posedge i_Clk);
    if (!Reset) stall_exp = '0;
    else if (last_f && stall_exp != 32'hFFFF_FFFF) stall_exp = stall_exp + 32'd1;
    @(negedge i_Clk);
  endtask

  task automatic test_reset();
    cyc_t tbl[$];
    exp_t e;
    logic [7:0] o;
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 1, 2'b01, 5'd8, 5'd8, 5'd0, 8'b11111_000));
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'b00000_000));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb.pop_front();
      o = sample_outs();
      $display("reset step=%0d outs=%b exp=%b stall=%0d", i, o, e.outs, bus.o_StallCnt);
      checks++;
      if (o !== e.outs) begin failures++; $display("FAIL reset.outs step=%0d got=%b want=%b", i, o, e.outs); end
      checks++;
      if (bus.o_StallCnt !== e.cnt) begin failures++; $display("FAIL reset.stallcnt step=%0d got=%0d want=%0d", i, bus.o_StallCnt, e.cnt); end
      tick();
    end
  endtask

  task automatic test_zero_wait();
    cyc_t tbl[$];
    exp_t e;
    logic [7:0] o;
    tbl.push_back(mk(1, 1, 0, 1, 2'b00, 5'd0, 5'd0, 5'd0, 8'b00000_100));
    tbl.push_back(mk(1, 1, 0, 1, 2'b00, 5'd0, 5'd0, 5'd0, 8'b00000_100));
    tbl.push_back(mk(1, 0, 1, 1, 2'b00, 5'd0, 5'd0, 5'd0, 8'b00000_100));
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'b00000_000));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb.pop_front();
      o = sample_outs();
      $display("zero_wait step=%0d outs=%b exp=%b stall=%0d", i, o, e.outs, bus.o_StallCnt);
      checks++;
      if (o !== e.outs) begin failures++; $display("FAIL zero_wait.outs step=%0d got=%b want=%b", i, o, e.outs); end
      checks++;
      if (bus.o_StallCnt !== e.cnt) begin failures++; $display("FAIL zero_wait.stallcnt step=%0d got=%0d want=%0d", i, bus.o_StallCnt, e.cnt); end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    cyc_t tbl[$];
    exp_t e;
    logic [7:0] o;
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 1, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'b11111_100));
    tbl.push_back(mk(1, 0, 1, 1, 2'b00, 5'd0, 5'd0, 5'd0, 8'b00000_100));
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'b00000_000));
    tbl.push_back(mk(1, 0, 0, 1, 2'b00, 5'd0, 5'd0, 5'd0, 8'b00000_000));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb.pop_front();
      o = sample_outs();
      $display("mem_wait step=%0d outs=%b exp=%b stall=%0d", i, o, e.outs, bus.o_StallCnt);
      checks++;
      if (o !== e.outs) begin failures++; $display("FAIL mem_wait.outs step=%0d got=%b want=%b", i, o, e.outs); end
      checks++;
      if (bus.o_StallCnt !== e.cnt) begin failures++; $display("FAIL mem_wait.stallcnt step=%0d got=%0d want=%0d", i, bus.o_StallCnt, e.cnt); end
      tick();
    end
  endtask

  task automatic test_load_use();
    cyc_t tbl[$];
    exp_t e;
    logic [7:0] o;
    tbl.push_back(mk(1, 0, 0, 0, 2'b01, 5'd8, 5'd0, 5'd8, 8'b00011_010));
    tbl.push_back(mk(1, 0, 0, 0, 2'b01, 5'd0, 5'd0, 5'd0, 8'b00000_000));
    tbl.push_back(mk(1, 0, 0, 0, 2'b01, 5'd8, 5'd8, 5'd3, 8'b00011_010));
    tbl.push_back(mk(1, 0, 0, 0, 2'b10, 5'd8, 5'd0, 5'd8, 8'b00000_000));
    tbl.push_back(mk(1, 0, 0, 0, 2'b01, 5'd8, 5'd3, 5'd4, 8'b00000_000));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb.pop_front();
      o = sample_outs();
      $display("load_use step=%0d outs=%b exp=%b stall=%0d", i, o, e.outs, bus.o_StallCnt);
      checks++;
      if (o !== e.outs) begin failures++; $display("FAIL load_use.outs step=%0d got=%b want=%b", i, o, e.outs); end
      checks++;
      if (bus.o_StallCnt !== e.cnt) begin failures++; $display("FAIL load_use.stallcnt step=%0d got=%0d want=%0d", i, bus.o_StallCnt, e.cnt); end
      tick();
    end
  endtask

  task automatic test_hazard_during_wait();
    cyc_t tbl[$];
    exp_t e;
    logic [7:0] o;
    tbl.push_back(mk(1, 1, 0, 0, 2'b01, 5'd5, 5'd5, 5'd0, 8'b11111_100));
    tbl.push_back(mk(1, 1, 0, 0, 2'b01, 5'd5, 5'd5, 5'd0, 8'b11111_100));
    tbl.push_back(mk(1, 1, 0, 1, 2'b01, 5'd5, 5'd5, 5'd0, 8'b00000_100));
    tbl.push_back(mk(1, 0, 0, 0, 2'b01, 5'd5, 5'd5, 5'd0, 8'b00011_010));
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 5'd5, 5'd5, 5'd0, 8'b00000_000));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb.pop_front();
      o = sample_outs();
      $display("hazard_wait step=%0d outs=%b exp=%b stall=%0d", i, o, e.outs, bus.o_StallCnt);
      checks++;
      if (o !== e.outs) begin failures++; $display("FAIL hazard_wait.outs step=%0d got=%b want=%b", i, o, e.outs); end
      checks++;
      if (bus.o_StallCnt !== e.cnt) begin failures++; $display("FAIL hazard_wait.stallcnt step=%0d got=%0d want=%0d", i, bus.o_StallCnt, e.cnt); end
      tick();
    end
  endtask

  // TIMEOUT_CYCLES = 4: one RUN request cycle, four MEM_WAIT cycles, then ERROR.
  task automatic test_timeout();
    cyc_t tbl[$];
    exp_t e;
    logic [7:0] o;
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'b11111_100));
    tbl.push_back(mk(1, 1, 0, 1, 2'b00, 5'd0, 5'd0, 5'd0, 8'b11111_001));
    tbl.push_back(mk(1, 1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'b11111_001));
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'b11111_000));
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'b00000_000));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb.pop_front();
      o = sample_outs();
      $display("timeout step=%0d outs=%b exp=%b stall=%0d", i, o, e.outs, bus.o_StallCnt);
      checks++;
      if (o !== e.outs) begin failures++; $display("FAIL timeout.outs step=%0d got=%b want=%b", i, o, e.outs); end
      checks++;
      if (bus.o_StallCnt !== e.cnt) begin failures++; $display("FAIL timeout.stallcnt step=%0d got=%0d want=%0d", i, bus.o_StallCnt, e.cnt); end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    cyc_t tbl[$];
    exp_t e;
    logic [7:0] o;
    tbl.push_back(mk(1, 1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'b11111_100));
    tbl.push_back(mk(1, 1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'b11111_100));
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 8'b11111_000));
    tbl.push_back(mk(1, 0, 0, 1, 2'b00, 5'd0, 5'd0, 5'd0, 8'b00000_000));
    tbl.push_back(mk(1, 1, 0, 1, 2'b00, 5'd0, 5'd0, 5'd0, 8'b00000_100));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb.pop_front();
      o = sample_outs();
      $display("reset_mid_wait step=%0d outs=%b exp=%b stall=%0d", i, o, e.outs, bus.o_StallCnt);
      checks++;
      if (o !== e.outs) begin failures++; $display("FAIL reset_mid_wait.outs step=%0d got=%b want=%b", i, o, e.outs); end
      checks++;
      if (bus.o_StallCnt !== e.cnt) begin failures++; $display("FAIL reset_mid_wait.stallcnt step=%0d got=%0d want=%0d", i, bus.o_StallCnt, e.cnt); end
      tick();
    end
  endtask

  initial begin
    @(negedge i_Clk);
    test_reset();
    test_zero_wait();
    test_mem_wait();
    test_load_use();
    test_hazard_during_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the active-low write enables (WE_n) of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and a bubble-insert flush for ID/EX.
- Sequences variable-latency data-memory accesses via a req/ack handshake.
- Inserts load-use bubbles and traps a hung memory with a timeout error state.

Parameters:
- TIMEOUT_CYCLES, 256: max MEM_WAIT cycles before entering ERROR; legal range 2..65535.
- CNT_W, 16: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- i_Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- i_MemRead_M  in  1  M-stage instruction reads data memory.
- i_MemWrite_M  in  1  M-stage instruction writes data memory.
- i_MemAck  in  1  memory completion; single-cycle pulse, legal only while o_MemReq=1.
- i_MemtoReg_E  in  2  E-stage MemtoReg; 2'b01 = load.
- i_WriteReg_E  in  5  E-stage destination register.
- i_Rs_D, i_Rt_D  in  5 each  D-stage source registers.
- o_MemReq  out  1  memory request, held until ack.
- o_WE_n_F, o_WE_n_D, o_WE_n_E, o_WE_n_M, o_WE_n_W  out  1 each  active-low stage enables (0 = load, 1 = hold).
- o_Flush_E  out  1  ID/EX loads a bubble (all control bits 0) on this edge.
- o_BusErr  out  1  sticky memory-timeout flag.
- o_StallCnt  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Reset enters RUN; wait counter = 0; o_BusErr = 0; o_StallCnt = 0.
- All WE_n, o_MemReq and o_Flush_E are combinational from state and inputs. While Reset = 0 they are forced to: WE_n = 1, o_MemReq = 0, o_Flush_E = 0.
- acc = i_MemRead_M | i_MemWrite_M.
- RUN, acc = 1:
  - o_MemReq = 1.
  - If i_MemAck = 1 in the same cycle (zero-wait memory): all WE_n = 0, stay in RUN, no stall.
  - Otherwise: all WE_n = 1, o_Flush_E = 0, next state MEM_WAIT, counter cleared.
- MEM_WAIT:
  - o_MemReq = 1; all WE_n = 1; counter increments each cycle.
  - On i_MemAck: all WE_n = 0 in that cycle, next state RUN, counter cleared. The M instruction advances on that edge, so it is never re-requested.
  - If counter == TIMEOUT_CYCLES-1 and no ack: next state ERROR.
  - Ack and timeout in the same cycle: ack wins.
- RUN, acc = 0: o_MemReq = 0.
  - Load-use check: i_MemtoReg_E == 2'b01, i_WriteReg_E != 0, and i_WriteReg_E equals i_Rs_D or i_Rt_D.
  - If true: o_WE_n_F = 1, o_WE_n_D = 1, o_Flush_E = 1, o_WE_n_E = 0, o_WE_n_M = 0, o_WE_n_W = 0.
  - Otherwise: all WE_n = 0, o_Flush_E = 0.
- Priority: memory stall over load-use. While frozen for memory, o_Flush_E = 0 even if a hazard exists; the hazard is re-evaluated after release.
- ERROR: o_BusErr = 1 (registered, set on entry); all WE_n = 1; o_MemReq = 0; i_MemAck ignored. Exit only by Reset.
- Reset mid-MEM_WAIT: o_MemReq drops asynchronously. Memory must abandon the transaction.
- i_MemAck while o_MemReq = 0: ignored.

Optional Feature:
- Macro PIPE_STALL_CNT_EN.
- Defined: o_StallCnt increments on each clock where o_WE_n_F = 1 and Reset = 1; saturates at 32'hFFFF_FFFF; cleared by Reset.
- Undefined: counter logic is omitted and o_StallCnt is tied to 0. The port list is unchanged.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum (RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2);
  - constant MEMTOREG_LOAD = 2'b01;
  - constant REG_ZERO = 5'd0.
- One sub-module, pipe_wait_timer: CNT_W-bit counter with clear/enable inputs and a terminal-count output at TIMEOUT_CYCLES-1.
- FSM and hazard logic stay in pipe_stall_ctrl.

Test Plan:
- Reset low 3 cycles, release: all WE_n = 0, o_MemReq = 0, o_BusErr = 0, state RUN.
- i_MemRead_M = 1 with i_MemAck = 1 in the same cycle: o_MemReq = 1, all WE_n = 0, no MEM_WAIT entry, o_StallCnt stays 0.
- i_MemWrite_M = 1, ack after 3 wait cycles: WE_n = 1 for 3 cycles, 0 on the ack cycle, then RUN. With PIPE_STALL_CNT_EN, o_StallCnt = 3.
- i_MemtoReg_E = 01, i_WriteReg_E = 8, i_Rt_D = 8, acc = 0: o_WE_n_F = o_WE_n_D = 1, o_Flush_E = 1, E/M/W enables 0. Repeat with i_WriteReg_E = 0: no stall.
- TIMEOUT_CYCLES = 4, acc = 1, no ack: ERROR after 4 MEM_WAIT cycles, o_BusErr = 1, all WE_n = 1, late ack ignored; Reset clears.
- Load-use hazard concurrent with memory stall: o_Flush_E = 0 throughout MEM_WAIT; bubble inserted on the first RUN cycle after ack if the hazard persists.
